// File: rtl/led_pattern_gen.sv
// led_pattern_gen: LED pattern sequencer with run control, a step prescaler
// and four display modes (fill/drain, bounce, chase, blink). A phase counter
// walks 0..2N-1; the LED image is a pure function of (MODE, phase) and is
// registered on the same edge as the phase it shows.
module led_pattern_gen #(
    parameter int N_LED = 8,
    parameter int DIV_W = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             CLEAR,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] DIV,
    output logic [N_LED-1:0] O,
    output logic             STEP,
    output logic             WRAP,
    output logic             RUNNING
);

    localparam int             P_W    = $clog2(2 * N_LED);
    localparam logic [P_W-1:0] P_LAST = P_W'(2 * N_LED - 1);

    localparam logic [N_LED-1:0] ONE_HOT0 = N_LED'(1);
    localparam logic [N_LED-1:0] ALL_ON   = '1;

    logic             run;
    logic [DIV_W-1:0] cnt;
    logic [P_W-1:0]   phase;

    logic             run_next;
    logic [DIV_W-1:0] cnt_next;
    logic [P_W-1:0]   phase_next;
    logic             step_now;
    logic             wrap_now;

    // LED image for a given mode and phase. Bit N_LED-1 is the top LED.
    // Built from shifts only so no variable bit-select is needed.
    function automatic logic [N_LED-1:0] pattern(input logic [1:0] mode,
                                                 input logic [P_W-1:0] ph);
        logic [N_LED-1:0] pat;
        int p;
        int k;
        int lit;
        p   = int'(ph);
        k   = (p >= N_LED) ? (p - N_LED) : p;
        pat = '0;
        case (mode)
            2'd0: begin
                // Fill grows from the top, then drains back toward the top.
                lit = (p < N_LED) ? (p + 1) : (N_LED - k);
                pat = ~(ALL_ON >> lit);
            end
            2'd1: begin
                // Walk down in the first half, back up in the second half;
                // the end LEDs appear on two consecutive phases.
                pat = (p < N_LED) ? (ONE_HOT0 << (N_LED - 1 - p))
                                  : (ONE_HOT0 << k);
            end
            2'd2: pat = ONE_HOT0 << (N_LED - 1 - k);
            default: pat = ph[0] ? '0 : ALL_ON;
        endcase
        return pat;
    endfunction

    // Next-state: run flag, prescaler and phase. CLEAR beats stepping; STOP
    // suppresses a step on the very edge it is sampled.
    always_comb begin
        run_next   = STOP ? 1'b0 : (START ? 1'b1 : run);
        cnt_next   = cnt;
        phase_next = phase;
        step_now   = 1'b0;
        wrap_now   = 1'b0;
        if (CLEAR) begin
            cnt_next   = '0;
            phase_next = '0;
        end else if (run && !STOP) begin
            // >= so that lowering DIV below the running count steps at once.
            if (cnt >= DIV) begin
                cnt_next   = '0;
                step_now   = 1'b1;
                wrap_now   = (phase == P_LAST);
                phase_next = wrap_now ? '0 : phase + 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    // State and registered outputs; O always shows the phase being written.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            run   <= 1'b0;
            cnt   <= '0;
            phase <= '0;
            O     <= '0;
            STEP  <= 1'b0;
            WRAP  <= 1'b0;
        end else begin
            run   <= run_next;
            cnt   <= cnt_next;
            phase <= phase_next;
            O     <= pattern(MODE, phase_next);
            STEP  <= step_now;
            WRAP  <= wrap_now;
        end
    end

    assign RUNNING = run;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: an N=8 and an N=4 instance share one stimulus
// stream. A cycle model computes the expected outputs of both from the
// pattern rules; directed vectors add hand-computed literal expectations.
module tb_led_pattern_gen;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       CLEAR = 1'b0;
    logic [1:0] MODE = 2'd0;
    logic [3:0] DIV = 4'd3;

    logic [7:0] o8;
    logic       step8, wrap8, run8;
    logic [3:0] o4;
    logic       step4, wrap4, run4;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 CLK = ~CLK;

    led_pattern_gen #(.N_LED(8), .DIV_W(4)) dut8 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .MODE(MODE), .DIV(DIV), .O(o8), .STEP(step8), .WRAP(wrap8), .RUNNING(run8)
    );

    led_pattern_gen #(.N_LED(4), .DIV_W(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CLEAR(CLEAR),
        .MODE(MODE), .DIV(DIV), .O(o4), .STEP(step4), .WRAP(wrap4), .RUNNING(run4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected LED image straight from the pattern rules.
    function automatic logic [31:0] pat(input int mode, input int p, input int n);
        int k;
        int c;
        longint v;
        k = p % n;
        case (mode)
            0: begin
                c = (p < n) ? p + 1 : n - k;
                v = ((longint'(1) << c) - 1) << (n - c);
            end
            1: v = (p < n) ? (longint'(1) << (n - 1 - p)) : (longint'(1) << k);
            2: v = longint'(1) << (n - 1 - k);
            default: v = (p % 2 == 0) ? ((longint'(1) << n) - 1) : 0;
        endcase
        return v[31:0];
    endfunction

    // Model state for [0]=N8, [1]=N4
    int          ns[2] = '{8, 4};
    int          m_run[2], m_cnt[2], m_ph[2];
    logic [31:0] m_o[2];
    bit          m_step[2], m_wrap[2];

    initial begin
        forever begin
            @(posedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (!RST_N) begin
                    m_run[i] = 0; m_cnt[i] = 0; m_ph[i] = 0;
                    m_o[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
                end else begin
                    m_step[i] = 0;
                    m_wrap[i] = 0;
                    if (CLEAR) begin
                        m_cnt[i] = 0;
                        m_ph[i]  = 0;
                    end else if (m_run[i] != 0 && !STOP) begin
                        if (m_cnt[i] >= int'(DIV)) begin
                            m_cnt[i]  = 0;
                            m_step[i] = 1;
                            m_wrap[i] = (m_ph[i] == 2 * ns[i] - 1);
                            m_ph[i]   = (m_ph[i] + 1) % (2 * ns[i]);
                        end else begin
                            m_cnt[i]++;
                        end
                    end
                    if (STOP) m_run[i] = 0;
                    else if (START) m_run[i] = 1;
                    m_o[i] = pat(int'(MODE), m_ph[i], ns[i]);
                end
            end
        end
    end

    // Every cycle after the first reset edge, both instances against the model.
    initial begin
        forever begin
            @(negedge CLK);
            if (cmp_en) begin
                chk("o8",    {24'd0, o8},    m_o[0]);
                chk("step8", {31'd0, step8}, {31'd0, m_step[0]});
                chk("wrap8", {31'd0, wrap8}, {31'd0, m_wrap[0]});
                chk("run8",  {31'd0, run8},  (m_run[0] != 0) ? 32'd1 : 32'd0);
                chk("o4",    {28'd0, o4},    m_o[1]);
                chk("step4", {31'd0, step4}, {31'd0, m_step[1]});
                chk("wrap4", {31'd0, wrap4}, {31'd0, m_wrap[1]});
                chk("run4",  {31'd0, run4},  (m_run[1] != 0) ? 32'd1 : 32'd0);
            end
        end
    end

    // Wait (bounded) for the next STEP on the N=8 instance; gap = cycles waited.
    task automatic wait_step(output int gap);
        gap = 0;
        do begin
            @(negedge CLK);
            gap++;
        end while (!step8 && gap < 40);
        chk("step_seen", {31'd0, step8}, 32'd1);
    endtask

    logic [7:0] fill_tab[16] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                 8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    logic [7:0] bnc_tab[16]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        int gap;
        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_o8",    {24'd0, o8},    32'h0);
        chk("rst_run8",  {31'd0, run8},  32'd0);
        chk("rst_step8", {31'd0, step8}, 32'd0);
        cmp_en = 1'b1;
        RST_N  = 1'b1;
        @(negedge CLK);
        chk("rel_o8", {24'd0, o8}, 32'h80);
        chk("rel_o4", {28'd0, o4}, 32'h8);

        // Fill/drain, DIV=3: one phase every 4 cycles, WRAP on return to 80
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            wait_step(gap);
            chk("fill_o", {24'd0, o8}, {24'd0, fill_tab[j % 16]});
            if (j > 1) chk("fill_gap", gap, 32'd4);
            chk("fill_wrap", {31'd0, wrap8}, (j == 16) ? 32'd1 : 32'd0);
        end

        // Bounce, DIV=0: a step every cycle
        MODE = 2'd1; DIV = 4'd0; CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        chk("bnc_clr_o", {24'd0, o8}, 32'h80);
        chk("bnc_clr_step", {31'd0, step8}, 32'd0);
        for (int j = 1; j <= 16; j++) begin
            @(negedge CLK);
            chk("bnc_o", {24'd0, o8}, {24'd0, bnc_tab[j % 16]});
            chk("bnc_step", {31'd0, step8}, 32'd1);
        end

        // Chase: stop at 10, hold, restart
        MODE = 2'd2; DIV = 4'd1; CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        chk("chase_o0", {24'd0, o8}, 32'h80);
        repeat (3) wait_step(gap);
        chk("chase_o3", {24'd0, o8}, 32'h10);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        chk("stop_run", {31'd0, run8}, 32'd0);
        repeat (20) begin
            @(negedge CLK);
            chk("hold_o", {24'd0, o8}, 32'h10);
            chk("hold_step", {31'd0, step8}, 32'd0);
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("restart_run", {31'd0, run8}, 32'd1);
        chk("restart_o", {24'd0, o8}, 32'h10);
        @(negedge CLK);
        chk("restart_nostep", {31'd0, step8}, 32'd0);
        @(negedge CLK);
        chk("restart_step", {31'd0, step8}, 32'd1);
        chk("restart_o8", {24'd0, o8}, 32'h08);
        START = 1'b1; STOP = 1'b1;
        @(negedge CLK);
        START = 1'b0; STOP = 1'b0;
        chk("both_run", {31'd0, run8}, 32'd0);

        // CLEAR at P=11, then MODE 0->3 at even phase
        MODE = 2'd0; DIV = 4'd0; CLEAR = 1'b1; START = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0; START = 1'b0;
        chk("clr_p0", {24'd0, o8}, 32'h80);
        repeat (11) @(negedge CLK);
        chk("p11_o", {24'd0, o8}, 32'hF8);
        CLEAR = 1'b1; DIV = 4'd7;
        @(negedge CLK);
        chk("clr_o", {24'd0, o8}, 32'h80);
        chk("clr_step", {31'd0, step8}, 32'd0);
        chk("clr_run", {31'd0, run8}, 32'd1);
        CLEAR = 1'b0; MODE = 2'd3;
        @(negedge CLK);
        chk("blink_o", {24'd0, o8}, 32'hFF);

        // DIV lowered from 7 to 2 while CNT=5
        repeat (4) begin
            @(negedge CLK);
            chk("div7_nostep", {31'd0, step8}, 32'd0);
        end
        DIV = 4'd2;
        @(negedge CLK);
        chk("div_low_step", {31'd0, step8}, 32'd1);
        chk("div_low_o", {24'd0, o8}, 32'h00);
        wait_step(gap);
        chk("div_low_gap", gap, 32'd3);
        chk("div_low_o2", {24'd0, o8}, 32'hFF);

        // Reset mid-run with N=4 at P=6
        MODE = 2'd0; DIV = 4'd0; CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        repeat (6) @(negedge CLK);
        chk("n4_p6_o", {28'd0, o4}, 32'hC);
        chk("n8_p6_o", {24'd0, o8}, 32'hFE);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mid_rst_o4",    {28'd0, o4},    32'h0);
        chk("mid_rst_run4",  {31'd0, run4},  32'd0);
        chk("mid_rst_step4", {31'd0, step4}, 32'd0);
        chk("mid_rst_wrap4", {31'd0, wrap4}, 32'd0);
        chk("mid_rst_o8",    {24'd0, o8},    32'h0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("mid_rel_o4", {28'd0, o4}, 32'h8);
        chk("mid_rel_o8", {24'd0, o8}, 32'h80);

        repeat (3) @(negedge CLK);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
